// File: rtl/spi_gyro_responder.sv
// spi_gyro_responder
//   SPI mode-3 slave standing in for the L3G4200D gyro behind a PmodGYRO.
//   It decodes {RW, MS, A[5:0]} command bytes, serves WHO_AM_I, CTRL_REG1-5,
//   STATUS and the temperature/axis data registers, and reports every
//   committed CTRL register write on a one-clk strobe.
//   Sensor inputs are snapshotted at frame start, so a frame always reads
//   one coherent sample.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   ss, sclk, mosi        SPI inputs, asynchronous to clk
//   miso, miso_oe         SPI data out and its drive enable
//   temp_in, x_in..z_in   live sensor values
//   wr_strobe/addr/data   one-clk report of a committed register write
//   ctrl_reg1..5          current CTRL_REG1-5 contents
//   busy                  high while the frame FSM is not IDLE
module spi_gyro_responder #(
   parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
   parameter logic [7:0] CTRL1_RST    = 8'h07,
   parameter int         SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ss,
   input  logic        sclk,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic [7:0]  temp_in,
   input  logic [15:0] x_in,
   input  logic [15:0] y_in,
   input  logic [15:0] z_in,
   output logic        wr_strobe,
   output logic [5:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic [7:0]  ctrl_reg1,
   output logic [7:0]  ctrl_reg2,
   output logic [7:0]  ctrl_reg3,
   output logic [7:0]  ctrl_reg4,
   output logic [7:0]  ctrl_reg5,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ADDR, RDATA, WDATA} state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic ss_s, sclk_s, mosi_s;
   logic ss_d, sclk_d;
   logic ss_rise, ss_fall, sclk_rise, sclk_fall;

   logic [2:0] bit_cnt;
   logic       byte_done;
   logic [7:0] rx_shift, rx_next;
   logic [7:0] tx_shift;
   logic [5:0] addr, addr_next;
   logic       ms;
   logic       lockout;

   logic [7:0]  temp_snap;
   logic [15:0] x_snap, y_snap, z_snap;

   // NOTE: synchronizer and edge-detect flops are deliberately not reset:
   // the reset path needs the true level of ss to decide on lockout, and a
   // reset value would fake an edge on release.
   always_ff @(posedge clk) begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
   end

   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign ss_rise   = ss_s & ~ss_d;
   assign ss_fall   = ~ss_s & ss_d;
   // A deselect in the same clk as an sclk edge wins: the edge is dropped.
   assign sclk_rise = sclk_s & ~sclk_d & ~ss_rise;
   assign sclk_fall = ~sclk_s & sclk_d & ~ss_rise;

   assign byte_done = (bit_cnt == 3'd7);
   assign rx_next   = {rx_shift[6:0], mosi_s};
   assign addr_next = ms ? addr + 6'd1 : addr;
   assign busy      = (state != IDLE);

   function automatic logic [7:0] reg_read(input logic [5:0] a);
      case (a)
         6'h0F:   return WHO_AM_I_VAL;
         6'h20:   return ctrl_reg1;
         6'h21:   return ctrl_reg2;
         6'h22:   return ctrl_reg3;
         6'h23:   return ctrl_reg4;
         6'h24:   return ctrl_reg5;
         6'h26:   return temp_snap;
         6'h27:   return 8'h0F;
         6'h28:   return x_snap[7:0];
         6'h29:   return x_snap[15:8];
         6'h2A:   return y_snap[7:0];
         6'h2B:   return y_snap[15:8];
         6'h2C:   return z_snap[7:0];
         6'h2D:   return z_snap[15:8];
         default: return 8'h00;
      endcase
   endfunction

   // NOTE: state registers use non-blocking assignments so every flop sees
   // the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // NOTE: state_n takes its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n = state;
      if (ss_rise) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:  if (ss_fall && !lockout) state_n = ADDR;
            ADDR:  if (sclk_rise && byte_done) state_n = rx_next[7] ? RDATA : WDATA;
            RDATA: state_n = RDATA;
            WDATA: state_n = WDATA;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         ctrl_reg1 <= CTRL1_RST;
         ctrl_reg2 <= '0;
         ctrl_reg3 <= '0;
         ctrl_reg4 <= '0;
         ctrl_reg5 <= '0;
         temp_snap <= '0;
         x_snap    <= '0;
         y_snap    <= '0;
         z_snap    <= '0;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         addr      <= '0;
         ms        <= 1'b0;
         // A reset landing inside a frame must not let the rest of that
         // frame be decoded from the middle.
         lockout   <= ~ss_s;
      end else begin
         wr_strobe <= 1'b0;
         if (ss_rise) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            lockout <= 1'b0;
            bit_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_fall && !lockout) begin
                     temp_snap <= temp_in;
                     x_snap    <= x_in;
                     y_snap    <= y_in;
                     z_snap    <= z_in;
                     bit_cnt   <= '0;
                     miso      <= 1'b0;
                     miso_oe   <= 1'b1;
                  end
               end
               ADDR: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_next;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        ms       <= rx_next[6];
                        addr     <= rx_next[5:0];
                        tx_shift <= reg_read(rx_next[5:0]);
                     end
                  end
               end
               RDATA: begin
                  if (sclk_fall) begin
                     miso    <= tx_shift[7];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        addr     <= addr_next;
                        tx_shift <= reg_read(addr_next);
                     end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                     end
                  end
               end
               WDATA: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_next;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        if (addr >= 6'h20 && addr <= 6'h24) begin
                           case (addr)
                              6'h20:   ctrl_reg1 <= rx_next;
                              6'h21:   ctrl_reg2 <= rx_next;
                              6'h22:   ctrl_reg3 <= rx_next;
                              6'h23:   ctrl_reg4 <= rx_next;
                              default: ctrl_reg5 <= rx_next;
                           endcase
                           wr_strobe <= 1'b1;
                           wr_addr   <= addr;
                           wr_data   <= rx_next;
                        end
                        addr <= addr_next;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_gyro_responder.sv
// tb_spi_gyro_responder
//   Directed bench for spi_gyro_responder: a mode-3 SPI master task drives
//   frames, and each scenario task compares the bytes and side outputs
//   against hand-computed values.
module tb_spi_gyro_responder;

   localparam int HALF = 8;   // sclk half-period in clk cycles

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ss = 1'b1;
   logic        sclk = 1'b1;
   logic        mosi = 1'b0;
   logic        miso, miso_oe;
   logic [7:0]  temp_in = 8'h00;
   logic [15:0] x_in = 16'h0000, y_in = 16'h0000, z_in = 16'h0000;
   logic        wr_strobe;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [7:0]  ctrl_reg1, ctrl_reg2, ctrl_reg3, ctrl_reg4, ctrl_reg5;
   logic        busy;

   int total = 0;
   int bad = 0;

   int         strobe_cnt = 0;
   logic [5:0] last_addr = '0;
   logic [7:0] last_data = '0;

   spi_gyro_responder dut (
      .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .temp_in(temp_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
      .ctrl_reg1(ctrl_reg1), .ctrl_reg2(ctrl_reg2), .ctrl_reg3(ctrl_reg3),
      .ctrl_reg4(ctrl_reg4), .ctrl_reg5(ctrl_reg5), .busy(busy)
   );

   always #5 clk = ~clk;

   // Each clk that wr_strobe is high counts once, so a stretched pulse
   // shows up as an extra count.
   always @(negedge clk) begin
      if (wr_strobe) begin
         strobe_cnt <= strobe_cnt + 1;
         last_addr  <= wr_addr;
         last_data  <= wr_data;
      end
   end

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sclk = 1'b0;
         mosi = tx[7-i];
         repeat (HALF) @(negedge clk);
         rx = {rx[6:0], miso};
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic select();
      @(negedge clk);
      ss = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic deselect();
      repeat (HALF) @(negedge clk);
      ss = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (10) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({miso, miso_oe, wr_strobe, busy} !== 4'b0000) begin
         $display("FAIL reset_outputs got miso/oe/strobe/busy=%b expected 0000",
                  {miso, miso_oe, wr_strobe, busy});
         bad++;
      end
      total++;
      if ({wr_addr, wr_data} !== 14'h0) begin
         $display("FAIL reset_wr_bus got addr=%h data=%h expected 00/00", wr_addr, wr_data);
         bad++;
      end
      total++;
      if ({ctrl_reg1, ctrl_reg2, ctrl_reg3, ctrl_reg4, ctrl_reg5} !== 40'h07_00_00_00_00) begin
         $display("FAIL reset_ctrl got %h %h %h %h %h expected 07 00 00 00 00",
                  ctrl_reg1, ctrl_reg2, ctrl_reg3, ctrl_reg4, ctrl_reg5);
         bad++;
      end
   endtask

   task automatic test_who_am_i();
      logic [7:0] rx;
      select();
      total++;
      if ({miso_oe, busy} !== 2'b11) begin
         $display("FAIL whoami_oe_selected got oe/busy=%b expected 11", {miso_oe, busy});
         bad++;
      end
      spi_bits(8'h8F, 8, rx);
      total++;
      if (rx !== 8'h00) begin
         $display("FAIL whoami_addr_phase_miso got %h expected 00", rx);
         bad++;
      end
      spi_bits(8'h00, 8, rx);
      total++;
      if (rx !== 8'hD3) begin
         $display("FAIL whoami_data got %h expected d3", rx);
         bad++;
      end
      deselect();
      total++;
      if ({miso_oe, busy, miso} !== 3'b000) begin
         $display("FAIL whoami_deselect got oe/busy/miso=%b expected 000", {miso_oe, busy, miso});
         bad++;
      end
   endtask

   task automatic test_write_readback();
      logic [7:0] rx;
      int s0;
      s0 = strobe_cnt;
      select();
      spi_bits(8'h20, 8, rx);
      spi_bits(8'h0F, 8, rx);
      deselect();
      total++;
      if (strobe_cnt - s0 != 1 || last_addr !== 6'h20 || last_data !== 8'h0F) begin
         $display("FAIL write_strobe got pulses=%0d addr=%h data=%h expected 1/20/0f",
                  strobe_cnt - s0, last_addr, last_data);
         bad++;
      end
      total++;
      if (ctrl_reg1 !== 8'h0F) begin
         $display("FAIL write_ctrl1 got %h expected 0f", ctrl_reg1);
         bad++;
      end
      select();
      spi_bits(8'hA0, 8, rx);
      spi_bits(8'h00, 8, rx);
      deselect();
      total++;
      if (rx !== 8'h0F) begin
         $display("FAIL readback_ctrl1 got %h expected 0f", rx);
         bad++;
      end
   endtask

   task automatic test_burst();
      logic [7:0] rx;
      logic [7:0] exp_b [6] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
      x_in = 16'h1234; y_in = 16'hABCD; z_in = 16'h8001; temp_in = 8'h5A;
      select();
      spi_bits(8'hE8, 8, rx);
      for (int i = 0; i < 6; i++) begin
         spi_bits(8'h00, 8, rx);
         if (i == 1) x_in = 16'hFFFF;
         total++;
         if (rx !== exp_b[i]) begin
            $display("FAIL burst_byte%0d got %h expected %h", i, rx, exp_b[i]);
            bad++;
         end
      end
      deselect();
      // Temperature and STATUS: 0x26 then 0x27 by auto-increment.
      select();
      spi_bits(8'hE6, 8, rx);
      spi_bits(8'h00, 8, rx);
      total++;
      if (rx !== 8'h5A) begin
         $display("FAIL burst_temp got %h expected 5a", rx);
         bad++;
      end
      spi_bits(8'h00, 8, rx);
      total++;
      if (rx !== 8'h0F) begin
         $display("FAIL burst_status got %h expected 0f", rx);
         bad++;
      end
      deselect();
      // The new x_in value is picked up on the next frame.
      select();
      spi_bits(8'hE8, 8, rx);
      spi_bits(8'h00, 8, rx);
      deselect();
      total++;
      if (rx !== 8'hFF) begin
         $display("FAIL burst_next_frame_x got %h expected ff", rx);
         bad++;
      end
   endtask

   task automatic test_wrap_no_incr();
      logic [7:0] rx;
      select();
      spi_bits(8'hFF, 8, rx);
      for (int i = 0; i < 2; i++) begin
         spi_bits(8'h00, 8, rx);
         total++;
         if (rx !== 8'h00) begin
            $display("FAIL wrap_byte%0d got %h expected 00", i, rx);
            bad++;
         end
      end
      deselect();
      // Auto-increment from 0x0E lands on WHO_AM_I as the second byte.
      select();
      spi_bits(8'hCE, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 8, rx);
      total++;
      if (rx !== 8'hD3) begin
         $display("FAIL incr_to_0f got %h expected d3", rx);
         bad++;
      end
      deselect();
      select();
      spi_bits(8'h8F, 8, rx);
      for (int i = 0; i < 3; i++) begin
         spi_bits(8'h00, 8, rx);
         total++;
         if (rx !== 8'hD3) begin
            $display("FAIL no_incr_byte%0d got %h expected d3", i, rx);
            bad++;
         end
      end
      deselect();
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      int s0;
      s0 = strobe_cnt;
      select();
      spi_bits(8'h21, 8, rx);
      spi_bits(8'hFF, 5, rx);
      deselect();
      total++;
      if (strobe_cnt != s0 || ctrl_reg2 !== 8'h00) begin
         $display("FAIL abort_no_write got pulses=%0d ctrl2=%h expected 0/00",
                  strobe_cnt - s0, ctrl_reg2);
         bad++;
      end
      select();
      spi_bits(8'h8F, 8, rx);
      spi_bits(8'h00, 8, rx);
      deselect();
      total++;
      if (rx !== 8'hD3) begin
         $display("FAIL abort_next_frame got %h expected d3", rx);
         bad++;
      end
   endtask

   task automatic test_write_burst();
      logic [7:0] rx;
      int s0;
      s0 = strobe_cnt;
      // Auto-increment write across CTRL_REG1/2.
      select();
      spi_bits(8'h60, 8, rx);
      spi_bits(8'h11, 8, rx);
      spi_bits(8'h22, 8, rx);
      deselect();
      total++;
      if (ctrl_reg1 !== 8'h11 || ctrl_reg2 !== 8'h22 || strobe_cnt - s0 != 2 || last_addr !== 6'h21) begin
         $display("FAIL write_burst got ctrl1=%h ctrl2=%h pulses=%0d last=%h expected 11/22/2/21",
                  ctrl_reg1, ctrl_reg2, strobe_cnt - s0, last_addr);
         bad++;
      end
      // CTRL_REG5 is the top of the writable window; 0x25 is outside it.
      s0 = strobe_cnt;
      select();
      spi_bits(8'h64, 8, rx);
      spi_bits(8'h5C, 8, rx);
      spi_bits(8'h77, 8, rx);
      deselect();
      total++;
      if (ctrl_reg5 !== 8'h5C || strobe_cnt - s0 != 1 || last_data !== 8'h5C) begin
         $display("FAIL write_edge got ctrl5=%h pulses=%0d data=%h expected 5c/1/5c",
                  ctrl_reg5, strobe_cnt - s0, last_data);
         bad++;
      end
      s0 = strobe_cnt;
      select();
      spi_bits(8'h0F, 8, rx);
      spi_bits(8'hAA, 8, rx);
      deselect();
      total++;
      if (strobe_cnt != s0) begin
         $display("FAIL write_readonly got pulses=%0d expected 0", strobe_cnt - s0);
         bad++;
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] rx;
      int oe_seen;
      select();
      spi_bits(8'hE8, 8, rx);
      spi_bits(8'h00, 4, rx);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      oe_seen = 0;
      for (int i = 0; i < 12; i++) begin
         spi_bits(8'h8F, 1, rx);
         if (miso_oe !== 1'b0) oe_seen++;
      end
      total++;
      if (oe_seen != 0 || busy !== 1'b0) begin
         $display("FAIL midrst_lockout got oe_high_bits=%0d busy=%b expected 0/0", oe_seen, busy);
         bad++;
      end
      total++;
      if (ctrl_reg1 !== 8'h07 || ctrl_reg5 !== 8'h00) begin
         $display("FAIL midrst_ctrl got ctrl1=%h ctrl5=%h expected 07/00", ctrl_reg1, ctrl_reg5);
         bad++;
      end
      deselect();
      select();
      spi_bits(8'h8F, 8, rx);
      spi_bits(8'h00, 8, rx);
      total++;
      if (rx !== 8'hD3 || miso_oe !== 1'b1) begin
         $display("FAIL midrst_recover got %h oe=%b expected d3/1", rx, miso_oe);
         bad++;
      end
      deselect();
   endtask

   initial begin
      test_reset();
      test_who_am_i();
      test_write_readback();
      test_burst();
      test_wrap_no_incr();
      test_abort();
      test_write_burst();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
